// File: rtl/p_uart_send_pkg.sv
// ============================================================================
// Module  : p_uart_send_pkg
// Brief   : Shared constants and FSM encoding for the packet UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package p_uart_send_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int PKT_BYTES       = 16;
    localparam int PKT_WIDTH       = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/p_uart_send_uart_send.sv
// ============================================================================
// Module  : uart_send
// Brief   : 8N1 byte serialiser with a registered TX line; byte_start is
//           ignored while a frame is in progress.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_send
    import p_uart_send_pkg::*;
#(
    parameter int BPS_CNT = 10
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       byte_start,
    input  logic [7:0] byte_data,
    output logic       uart_txd,
    output logic       byte_busy,
    output logic       byte_done
);

    localparam logic [15:0] c_bps_last      = 16'(BPS_CNT - 1);
    localparam logic [3:0]  c_stop_idx      = 4'(UART_FRAME_BITS - 1);
    localparam logic [3:0]  c_last_data_idx = 4'(UART_FRAME_BITS - 2);

    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_idx;
    logic [7:0]  r_data;
    logic        r_txd;
    logic        r_busy;
    logic        w_bit_end;

    assign w_bit_end = r_busy && (r_baud_cnt == c_bps_last);

    // Frame index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 4'd0;
            r_data     <= 8'd0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else if (!r_busy) begin
            if (byte_start) begin
                r_busy     <= 1'b1;
                r_data     <= byte_data;
                r_txd      <= 1'b0;
                r_baud_cnt <= 16'd0;
                r_bit_idx  <= 4'd0;
            end
        end else if (w_bit_end) begin
            r_baud_cnt <= 16'd0;
            if (r_bit_idx == c_stop_idx) begin
                r_busy <= 1'b0;
                r_txd  <= 1'b1;
            end else begin
                r_bit_idx <= r_bit_idx + 4'd1;
                r_txd     <= (r_bit_idx == c_last_data_idx) ? 1'b1 : r_data[r_bit_idx[2:0]];
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    assign uart_txd  = r_txd;
    assign byte_busy = r_busy;
    assign byte_done = w_bit_end && (r_bit_idx == c_stop_idx);

endmodule

`default_nettype wire

// File: rtl/p_uart_send.sv
// ============================================================================
// Module  : p_uart_send
// Brief   : Sends a 128-bit packet as 16 UART bytes, least significant first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module p_uart_send
    import p_uart_send_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 send_en,
    input  logic [PKT_WIDTH-1:0] send_data,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic [4:0]           tx_cnt,
    output logic                 send_done
);

    localparam int         BPS_CNT     = CLK_FREQ / UART_BPS;
    localparam logic [4:0] c_last_byte = 5'(PKT_BYTES - 1);

    logic                 r_en_d0;
    logic                 r_en_d1;
    logic                 w_start_flag;
    tx_state_t            r_state;
    logic [PKT_WIDTH-1:0] r_shadow;
    logic [4:0]           r_tx_cnt;
    logic                 r_tx_busy;
    logic                 r_send_done;
    logic                 w_byte_start;
    logic [7:0]           w_byte_data;
    logic                 w_byte_busy;
    logic                 w_byte_done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_en_d0 <= 1'b0;
            r_en_d1 <= 1'b0;
        end else begin
            r_en_d0 <= send_en;
            r_en_d1 <= r_en_d0;
        end
    end

    // Only a rising edge counts, so a held request produces a single packet.
    assign w_start_flag = r_en_d0 & ~r_en_d1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_shadow    <= '0;
            r_tx_cnt    <= 5'd0;
            r_tx_busy   <= 1'b0;
            r_send_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_flag) begin
                        r_shadow  <= send_data;
                        r_tx_cnt  <= 5'd0;
                        r_tx_busy <= 1'b1;
                        r_state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_byte_done) begin
                        r_tx_cnt <= r_tx_cnt + 5'd1;
                        if (r_tx_cnt == c_last_byte) begin
                            r_send_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    r_send_done <= 1'b0;
                    r_tx_busy   <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_byte_start = (r_state == ST_LOAD) && !w_byte_busy;
    assign w_byte_data  = r_shadow[{r_tx_cnt[3:0], 3'b000} +: 8];

    uart_send #(
        .BPS_CNT (BPS_CNT)
    ) u_uart_send (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .byte_start (w_byte_start),
        .byte_data  (w_byte_data),
        .uart_txd   (uart_txd),
        .byte_busy  (w_byte_busy),
        .byte_done  (w_byte_done)
    );

    assign tx_busy   = r_tx_busy;
    assign tx_cnt    = r_tx_cnt;
    assign send_done = r_send_done;

endmodule

`default_nettype wire

// File: tb/tb_p_uart_send.sv
// ============================================================================
// Module  : tb_p_uart_send
// Brief   : Self-checking bench for p_uart_send against a cycle-level line model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p_uart_send;

    localparam int BPS      = 10;
    localparam int FRAME    = 10 * BPS + 1;
    localparam int PKT_CYC  = 16 * FRAME;
    localparam int DONE_REL = 2 + 16 * 10 * BPS + 15;

    typedef struct {
        logic [127:0] data;
        logic [127:0] exp_pkt;
        int           hold;
        int           reraise;
        bit           chg;
        int           abort;
    } vec_t;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         send_en;
    logic [127:0] send_data;
    logic         uart_txd;
    logic         tx_busy;
    logic [4:0]   tx_cnt;
    logic         send_done;

    int checks   = 0;
    int failures = 0;
    int nbad[4];
    int frel[4];
    int fact[4];
    int fexp[4];
    vec_t vecs[7];

    p_uart_send #(
        .CLK_FREQ (50000000),
        .UART_BPS (5000000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .send_en   (send_en),
        .send_data (send_data),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_cnt    (tx_cnt),
        .send_done (send_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Line level t cycles after E2: byte k occupies 10 bits of BPS cycles then one idle cycle.
    function automatic int exp_txd(input logic [127:0] d, input int t);
        int k, o, b;
        if (t < 0 || t >= PKT_CYC) return 1;
        k = t / FRAME;
        o = t % FRAME;
        if (o == 10 * BPS) return 1;
        b = o / BPS;
        if (b == 0) return 0;
        if (b == 9) return 1;
        return int'(d[8 * k + b - 1]);
    endfunction

    function automatic int exp_cnt(input int rel);
        int n = 0;
        for (int k = 0; k < 16; k++)
            if (rel >= 2 + k * FRAME + 10 * BPS) n++;
        return n;
    endfunction

    function automatic string sname(input int s);
        case (s)
            0:       return "txd";
            1:       return "busy";
            2:       return "cnt";
            default: return "done";
        endcase
    endfunction

    function automatic void note(input int s, input int rel, input int act, input int exp);
        if (act != exp) begin
            if (nbad[s] == 0) begin
                frel[s] = rel;
                fact[s] = act;
                fexp[s] = exp;
            end
            nbad[s]++;
        end
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic report(input string name);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (nbad[s] != 0) begin
                failures++;
                $display("FAIL %s_%s: %0d bad cycles, first at rel %0d got %0d expected %0d",
                         name, sname(s), nbad[s], frel[s], fact[s], fexp[s]);
            end
            nbad[s] = 0;
        end
    endtask

    // rel counts the edges since E0 (the first edge sampling send_en=1).
    task automatic run_packet(input string name, input vec_t v);
        logic [127:0] got;
        int last, t, o, b;
        bit aborted;
        got     = '0;
        aborted = 1'b0;
        last    = DONE_REL + 1;
        if (v.hold + 20 > last) last = v.hold + 20;
        if (v.reraise + 20 > last) last = v.reraise + 20;
        @(negedge sys_clk);
        send_en   = 1'b1;
        send_data = v.data;
        for (int rel = 0; rel <= last; rel++) begin
            @(negedge sys_clk);
            send_en = (rel + 1 < v.hold) ||
                      (v.reraise >= 0 && rel >= v.reraise && rel < v.reraise + 2);
            if (v.chg && rel == 1) send_data = '1;
            if (rel == v.abort) begin
                sys_rst_n = 1'b0;
                send_en   = 1'b0;
                #1;
                report(name);
                check({name, "_rst_txd"},  128'(uart_txd),  128'd1);
                check({name, "_rst_busy"}, 128'(tx_busy),   128'd0);
                check({name, "_rst_cnt"},  128'(tx_cnt),    128'd0);
                check({name, "_rst_done"}, 128'(send_done), 128'd0);
                aborted = 1'b1;
                break;
            end
            if (rel == 1) check({name, "_busy_e1"}, 128'(tx_busy), 128'd1);
            if (rel == 2) check({name, "_txd_e2"}, 128'(uart_txd), 128'd0);
            if (rel >= 1) begin
                t = rel - 2;
                note(0, rel, int'(uart_txd), exp_txd(v.exp_pkt, t));
                note(1, rel, int'(tx_busy), int'(rel <= DONE_REL));
                note(2, rel, int'(tx_cnt), exp_cnt(rel));
                note(3, rel, int'(send_done), int'(rel == DONE_REL));
                if (t >= 0 && t < PKT_CYC) begin
                    o = t % FRAME;
                    b = o / BPS;
                    if (o < 10 * BPS && o % BPS == BPS / 2 && b >= 1 && b <= 8)
                        got[8 * (t / FRAME) + b - 1] = uart_txd;
                end
            end
        end
        if (!aborted) begin
            report(name);
            check({name, "_bytes"}, got, v.exp_pkt);
        end
    endtask

    initial begin
        vec_t v;
        for (int s = 0; s < 4; s++) nbad[s] = 0;
        sys_rst_n = 1'b0;
        send_en   = 1'b0;
        send_data = '0;
        repeat (2) @(negedge sys_clk);
        check("reset_txd",  128'(uart_txd),  128'd1);
        check("reset_busy", 128'(tx_busy),   128'd0);
        check("reset_cnt",  128'(tx_cnt),    128'd0);
        check("reset_done", 128'(send_done), 128'd0);
        sys_rst_n = 1'b1;

        vecs[0] = '{data: 128'h0F0E0D0C0B0A09080706050403020100, exp_pkt: 128'h0F0E0D0C0B0A09080706050403020100,
                    hold: 1, reraise: -1, chg: 1'b0, abort: -1};
        vecs[1] = '{data: {8{16'hAA55}}, exp_pkt: {8{16'hAA55}},
                    hold: 1, reraise: -1, chg: 1'b0, abort: -1};
        vecs[2] = '{data: 128'h0123456789ABCDEFFEDCBA9876543210, exp_pkt: 128'h0123456789ABCDEFFEDCBA9876543210,
                    hold: 3000, reraise: -1, chg: 1'b0, abort: -1};
        vecs[3] = '{data: 128'hDEADBEEFCAFEF00D123456789ABCDEF0, exp_pkt: 128'hDEADBEEFCAFEF00D123456789ABCDEF0,
                    hold: 1, reraise: 502, chg: 1'b0, abort: -1};
        vecs[4] = '{data: 128'hC3C33C3C00FF00FF8001800172277227, exp_pkt: 128'hC3C33C3C00FF00FF8001800172277227,
                    hold: 1, reraise: -1, chg: 1'b1, abort: -1};
        vecs[5] = '{data: 128'h000102030405060708090A0B0C0D0E0F, exp_pkt: 128'h000102030405060708090A0B0C0D0E0F,
                    hold: 2, reraise: -1, chg: 1'b0, abort: -1};
        vecs[6] = '{data: 128'h5A5A5A5AA5A5A5A5F0F0F0F00F0F0F0F, exp_pkt: 128'h5A5A5A5AA5A5A5A5F0F0F0F00F0F0F0F,
                    hold: 1, reraise: DONE_REL - 1, chg: 1'b0, abort: -1};

        for (int i = 0; i < 7; i++) run_packet($sformatf("v%0d", i), vecs[i]);

        // Abort in byte 7, data bit 3 (a zero bit), then confirm silence and a clean restart.
        v = vecs[0];
        v.abort = 2 + 7 * FRAME + 4 * BPS + BPS / 2;
        run_packet("abort", v);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            note(0, c, int'(uart_txd), 1);
            note(1, c, int'(tx_busy), 0);
            note(2, c, int'(tx_cnt), 0);
            note(3, c, int'(send_done), 0);
        end
        report("post_rst");
        run_packet("fresh", vecs[0]);

        for (int r = 0; r < 3; r++) begin
            v.data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.exp_pkt = v.data;
            v.hold    = int'($urandom_range(1, 4));
            v.reraise = int'($urandom_range(10, DONE_REL - 1));
            v.chg     = 1'($urandom_range(0, 1));
            v.abort   = -1;
            run_packet($sformatf("rnd%0d", r), v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
